// File: rtl/eth_line_pingpong_buf.sv
// Ping-pong line buffer: two banks of 2^ADDR_WIDTH words between pixel unpacker and line reader.
// Define LBUF_ERR_CNT_EN to add err_cnt, a saturating count of overflow-closed lines.
module eth_line_pingpong_buf #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [1:0]            lines_avail,
  output logic                  ovf
`ifdef LBUF_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CntOne = 1;

  typedef enum logic [1:0] {StEmpty, StFill, StFull, StDrain} bank_st_e;

  bank_st_e              bank_st_q [2];
  logic [ADDR_WIDTH:0]   len_q [2];
  logic                  wb_q, rb_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH:0]   rd_cnt_q;
  logic                  rd_valid_q, rd_last_q, ovf_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] mem [2*Depth];

  logic                wr_acc, wr_at_end, wr_close;
  logic                rd_live, issue, issue_last;
  logic [ADDR_WIDTH:0] rd_len;
  logic                live0, live1;

  always_comb begin
    wr_ready   = (bank_st_q[wb_q] == StEmpty || bank_st_q[wb_q] == StFill) && !flush;
    wr_acc     = wr_valid && wr_ready;
    wr_at_end  = &wr_ptr_q;
    wr_close   = wr_last || wr_at_end;
    rd_live    = bank_st_q[rb_q] == StFull || bank_st_q[rb_q] == StDrain;
    rd_len     = len_q[rb_q];
    issue      = rd_live && (rd_cnt_q < rd_len) && (!rd_valid_q || rd_ready) && !flush;
    issue_last = issue && (rd_cnt_q + CntOne == rd_len);
    live0      = bank_st_q[0] == StFull || bank_st_q[0] == StDrain;
    live1      = bank_st_q[1] == StFull || bank_st_q[1] == StDrain;
  end

  // Write and read sides only ever touch a bank in disjoint states, so they never collide.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      bank_st_q[0] <= StEmpty;
      bank_st_q[1] <= StEmpty;
      len_q[0]     <= '0;
      len_q[1]     <= '0;
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      wr_ptr_q     <= '0;
      rd_cnt_q     <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      if (wr_acc) begin
        if (wr_close) begin
          len_q[wb_q]     <= {1'b0, wr_ptr_q} + CntOne;
          bank_st_q[wb_q] <= StFull;
          wb_q            <= ~wb_q;
          wr_ptr_q        <= '0;
          if (!wr_last) begin
            ovf_q <= 1'b1;
          end
        end else begin
          bank_st_q[wb_q] <= StFill;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
      end
      if (issue) begin
        rd_valid_q <= 1'b1;
        rd_last_q  <= issue_last;
        if (issue_last) begin
          bank_st_q[rb_q] <= StEmpty;
          rb_q            <= ~rb_q;
          rd_cnt_q        <= '0;
        end else begin
          bank_st_q[rb_q] <= StDrain;
          rd_cnt_q        <= rd_cnt_q + 1'b1;
        end
      end else if (rd_valid_q && rd_ready) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
    end
  end

  // Storage has no reset; the read register holds whenever no read is issued.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[{wb_q, wr_ptr_q}] <= wr_data;
    end
    if (issue) begin
      rd_data_q <= mem[{rb_q, rd_cnt_q[ADDR_WIDTH-1:0]}];
    end
  end

`ifdef LBUF_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Survives flush on purpose: only a full reset clears the error history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (wr_acc && wr_at_end && !wr_last && err_cnt_q != 16'hffff) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_last     = rd_last_q;
  assign ovf         = ovf_q;
  assign lines_avail = {1'b0, live0} + {1'b0, live1};

endmodule

// File: tb/tb_eth_line_pingpong_buf.sv
// Self-checking bench for eth_line_pingpong_buf: directed scenarios plus randomized lines,
// checked against a word-queue reference model. Honours LBUF_ERR_CNT_EN when defined.
module tb_eth_line_pingpong_buf;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n, flush, wr_valid, wr_ready, wr_last;
  logic          rd_valid, rd_ready, rd_last, ovf;
  logic [DW-1:0] wr_data, rd_data;
  logic [1:0]    lines_avail;
`ifdef LBUF_ERR_CNT_EN
  logic [15:0]   err_cnt;
`endif

  eth_line_pingpong_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .lines_avail (lines_avail),
    .ovf         (ovf)
`ifdef LBUF_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted word is queued as {last, data}; a line closes on wr_last
  // or when it reaches DEPTH words, the latter being an overflow.
  logic [DW:0]   exp_q [$];
  int            model_cnt = 0;
  bit            model_ovf = 1'b0;
  int            model_err = 0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    logic [DW:0] e;
    check_eq("ovf", ovf, model_ovf);
`ifdef LBUF_ERR_CNT_EN
    check_eq("err_cnt", err_cnt, model_err);
`endif
    if (prev_hold) begin
      check_eq("hold_valid", rd_valid, 1'b1);
      check_eq("hold_data", rd_data, prev_data);
      check_eq("hold_last", rd_last, prev_last);
    end
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = 0;
      model_ovf = 1'b0;
      model_err = 0;
      prev_hold = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      model_cnt = 0;
      model_ovf = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("rd_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rd_data", rd_data, e[DW-1:0]);
          check_eq("rd_last", rd_last, e[DW]);
        end
      end
      if (wr_valid && wr_ready) begin
        model_cnt++;
        if (wr_last) begin
          exp_q.push_back({1'b1, wr_data});
          model_cnt = 0;
        end else if (model_cnt == DEPTH) begin
          exp_q.push_back({1'b1, wr_data});
          model_ovf = 1'b1;
          if (model_err < 65535) model_err++;
          model_cnt = 0;
        end else begin
          exp_q.push_back({1'b0, wr_data});
        end
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
      prev_last = rd_last;
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    bit acc = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = l;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = wr_ready;
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    if (!acc) check_eq("wr_timeout", 0, 1);
  endtask

  task automatic send_line(input logic [DW-1:0] base, input int n, input bit with_last);
    for (int k = 1; k <= n; k++) begin
      send_beat(base + DW'(k), with_last && (k == n));
    end
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rd_valid) break;
    end
    check_eq("drain_left", exp_q.size(), 0);
    check_eq("drain_valid", rd_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    @(negedge clk);
    check_eq({tag, "_rd_valid"}, rd_valid, 1'b0);
    check_eq({tag, "_lines"}, lines_avail, 2'd0);
    check_eq({tag, "_wr_ready"}, wr_ready, 1'b1);
    check_eq({tag, "_ovf"}, ovf, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    bit done;
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_rd_last", rd_last, 1'b0);
    check_eq("rst_lines", lines_avail, 2'd0);
    check_eq("rst_wr_ready", wr_ready, 1'b1);
    @(posedge clk);
    #1;

    // 4-word line, first valid two cycles after the wr_last beat, then back to back
    rd_ready = 1'b1;
    send_line(16'h0000, 4, 1'b1);
    @(negedge clk);
    check_eq("t1_valid_t1", rd_valid, 1'b0);
    check_eq("t1_lines_t1", lines_avail, 2'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t1_valid_run", rd_valid, 1'b1);
    end
    check_eq("t1_lines_end", lines_avail, 2'd0);
    @(negedge clk);
    check_eq("t1_valid_after", rd_valid, 1'b0);
    @(posedge clk);
    #1;

    // Both banks full with reader stalled, then gapless drain across the bank switch
    rd_ready = 1'b0;
    send_line(16'h0100, 8, 1'b1);
    send_line(16'h0200, 8, 1'b1);
    @(negedge clk);
    check_eq("t2_wr_ready", wr_ready, 1'b0);
    check_eq("t2_lines", lines_avail, 2'd2);
    @(posedge clk);
    #1 rd_ready = 1'b1;
    fork
      send_line(16'h0300, 8, 1'b1);
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        check_eq("t2_nogap", rd_valid, 1'b1);
      end
    join
    drain();

    // Overflow: 17 words without wr_last
    rd_ready = 1'b0;
    send_line(16'h0400, 17, 1'b0);
    @(negedge clk);
    check_eq("t3_ovf", ovf, 1'b1);
    check_eq("t3_lines", lines_avail, 2'd1);
    check_eq("t3_wr_ready", wr_ready, 1'b1);
`ifdef LBUF_ERR_CNT_EN
    check_eq("t3_err_cnt", err_cnt, 16'd1);
`endif
    @(posedge clk);
    #1;
    send_beat(16'h0412, 1'b1);
    drain();

    // 10-word line under random backpressure
    fork
      send_line(16'h0500, 10, 1'b1);
      repeat (80) begin
        @(posedge clk);
        #1 rd_ready = 1'($urandom);
      end
    join
    drain();

    // Flush mid-drain after 5 words
    rd_ready = 1'b0;
    send_line(16'h0600, 16, 1'b1);
    @(posedge clk);
    #1 rd_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 5; i++) begin
      @(negedge clk);
      if (rd_valid && rd_ready) cnt++;
    end
    check_eq("t5_handshakes", cnt, 5);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check_cleared("t5");
    @(posedge clk);
    #1;
    send_line(16'h0700, 2, 1'b1);
    drain();

    // Reset pulse in the middle of a write burst
    send_line(16'h0800, 3, 1'b0);
    wr_valid = 1'b1; wr_data = 16'h0804; wr_last = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr_valid = 1'b0;
    check_cleared("t6");
`ifdef LBUF_ERR_CNT_EN
    check_eq("t6_err_cnt", err_cnt, 16'd0);
`endif
    @(posedge clk);
    #1;
    send_line(16'h0900, 5, 1'b1);
    drain();

    // Random lines, some longer than a bank, with random gaps and backpressure
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int len = $urandom_range(1, 20);
          for (int k = 1; k <= len; k++) begin
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
            send_beat(DW'($urandom), k == len);
          end
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1 rd_ready = ($urandom_range(0, 2) != 0);
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
